// File: rtl/plot_queue.sv
// Write-side plot buffer for the framebuffer: range-checks plot requests, converts them to
// linear addresses, queues them and drains them whenever scan-out reads leave the RAM port free.
module plot_queue #(
    parameter int unsigned WIDTH  = 160,
    parameter int unsigned HEIGHT = 120,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   vga_x,
    input  logic [6:0]                   vga_y,
    input  logic [2:0]                   vga_colour,
    input  logic                         vga_plot,
    input  logic                         rd_req,
    input  logic [7:0]                   rd_x,
    input  logic [6:0]                   rd_y,
    output logic                         rd_valid,
    output logic [2:0]                   rd_colour,
    output logic [14:0]                  mem_addr,
    output logic                         mem_wren,
    output logic [2:0]                   mem_wdata,
    input  logic [2:0]                   mem_rdata,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         overflow,
    output logic                         oob
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [17:0]   fifo_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          oob_q, oob_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_inr_q, rd_inr_d;

    logic          plot_inr_s;
    logic          rd_inr_s;
    logic [14:0]   plot_addr_s;
    logic [14:0]   rd_addr_s;
    logic [17:0]   head_s;
    logic          full_s;
    logic          empty_s;
    logic          pop_s;
    logic          push_s;

    assign plot_inr_s  = (32'(vga_x) < WIDTH) && (32'(vga_y) < HEIGHT);
    assign rd_inr_s    = rd_req && (32'(rd_x) < WIDTH) && (32'(rd_y) < HEIGHT);
    assign plot_addr_s = 15'(vga_y) * 15'(WIDTH) + 15'(vga_x);
    assign rd_addr_s   = 15'(rd_y) * 15'(WIDTH) + 15'(rd_x);
    assign head_s      = fifo_q[rd_ptr_q];
    assign full_s      = (count_q == CW'(DEPTH));
    assign empty_s     = (count_q == {CW{1'b0}});

    // RAM port arbitration: an in-range scan-out read always owns the port
    always_comb begin
        mem_addr  = 15'd0;
        mem_wren  = 1'b0;
        mem_wdata = 3'd0;
        pop_s     = 1'b0;
        if (rd_inr_s) begin
            mem_addr = rd_addr_s;
        end else if (!empty_s) begin
            mem_addr  = head_s[17:3];
            mem_wdata = head_s[2:0];
            mem_wren  = 1'b1;
            pop_s     = 1'b1;
        end else begin
            mem_addr  = 15'd0;
            mem_wren  = 1'b0;
        end
    end

    // A full FIFO still accepts a plot when the head retires in the same cycle
    assign push_s = vga_plot && plot_inr_s && (!full_s || pop_s);

    // Next-state for pointers, occupancy, sticky flags and the read pipeline
    always_comb begin
        wr_ptr_d   = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d   = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        overflow_d = overflow_q || (vga_plot && plot_inr_s && !push_s);
        oob_d      = oob_q || (vga_plot && !plot_inr_s);
        rd_valid_d = rd_req;
        rd_inr_d   = rd_inr_s;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            overflow_q <= 1'b0;
            oob_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_inr_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            oob_q      <= oob_d;
            rd_valid_q <= rd_valid_d;
            rd_inr_q   <= rd_inr_d;
        end
    end

    // FIFO storage, entries packed as {addr, colour}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= 18'd0;
            end
        end else if (push_s) begin
            fifo_q[wr_ptr_q] <= {plot_addr_s, vga_colour};
        end else begin
            fifo_q[wr_ptr_q] <= fifo_q[wr_ptr_q];
        end
    end

    // Returning read data comes straight from the RAM; out-of-range reads return 0
    always_comb begin
        if (rd_valid_q && rd_inr_q) begin
            rd_colour = mem_rdata;
        end else begin
            rd_colour = 3'd0;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign oob        = oob_q;

endmodule
